icache_req_rr_arb: RTL and testbench
====================================

Name: icache_req_rr_arb

Overview:
- Parametrised successor of the icache tag-pipe request arbiter.
- Merges NUM_SRC request channels (demand fetch, snoop, prefetch, and future sources) into one tag-lookup request stream.
- Round-robin fairness; each grant is paired with one allocated MSHR index.
- One registered output stage at full throughput, so the tag pipe sees a registered vld/pld/index/source-id.

Parameters:
- NUM_SRC, 3, number of request sources; index 0 is the oldest-priority slot at reset.
- PLD_WIDTH, 64, request payload width in bits (set to $bits(pc_req_t) at instantiation).
- IDX_WIDTH, 3, MSHR entry index width.
- SRC_W, max(1,$clog2(NUM_SRC)), width of source id (localparam).
- CNT_WIDTH, 16, per-source grant counter width (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- src_vld  in  NUM_SRC  per-source request valid
- src_rdy  out  NUM_SRC  per-source accept; at most one bit set
- src_pld  in  NUM_SRC*PLD_WIDTH  flattened payloads; source i at [i*PLD_WIDTH +: PLD_WIDTH]
- alloc_vld  in  1  MSHR free entry available
- alloc_index  in  IDX_WIDTH  index of the free MSHR entry
- alloc_rdy  out  1  MSHR entry consumed this cycle
- tag_req_vld  out  1  registered request to tag pipe
- tag_req_rdy  in  1  tag pipe accepts
- tag_req_pld  out  PLD_WIDTH  registered winning payload
- tag_req_index  out  IDX_WIDTH  registered MSHR index bound to the request
- tag_req_src  out  SRC_W  registered id of the winning source
- grant_cnt  out  NUM_SRC*CNT_WIDTH  per-source grant counts (present only with ARB_GRANT_CNT_EN)

Behaviour:
- Reset, synchronous on clk when rst_n=0:
  - tag_req_vld=0, tag_req_pld=0, tag_req_index=0, tag_req_src=0.
  - RR pointer ptr=0; grant counters 0.
  - Reset mid-transfer drops any held request. Upstream retries it.
- Arbitration (combinational):
  - Search src_vld starting at ptr, ascending with wrap modulo NUM_SRC.
  - The first set bit is the winner w; any_vld = |src_vld.
- Output-stage condition: slot_free = !tag_req_vld || tag_req_rdy.
- load = any_vld && alloc_vld && slot_free. When load is high:
  - src_rdy[w]=1 and all other src_rdy bits are 0.
  - alloc_rdy=1.
  - Next cycle: tag_req_vld=1, tag_req_pld=src_pld[w], tag_req_index=alloc_index, tag_req_src=w.
  - ptr <= (w+1) mod NUM_SRC.
- No load, tag_req_vld && tag_req_rdy: tag_req_vld <= 0. Other registers hold.
- No load, no drain: all state holds. pld, index and src stay stable while tag_req_vld && !tag_req_rdy.
- alloc_vld=0: no grant, src_rdy=0, alloc_rdy=0, ptr unchanged. A request is never issued without an MSHR index.
- alloc_rdy is asserted only together with a src_rdy bit. It is never asserted on idle.
- Latency: accept to tag_req_vld is 1 cycle. Back-to-back drain and reload in the same cycle gives 1 request/cycle.
- Combinational paths: tag_req_rdy/alloc_vld/src_vld -> src_rdy/alloc_rdy. There is no path from inputs to any tag_req_* output.
- Fairness: a continuously asserting source waits at most NUM_SRC-1 grants.
- NUM_SRC=1: ptr is constant 0 and tag_req_src=0.
- Upstream sources must hold vld/pld until rdy. The arbiter may re-choose a different winner on a cycle with no load, because ptr is unchanged and priority is recomputed.

Optional Feature:
- Macro: ARB_GRANT_CNT_EN.
- Defined:
  - One CNT_WIDTH saturating counter per source, incremented on each cycle src_rdy[i]=1.
  - Saturates at all-ones; never wraps. Reset to 0.
  - Exposed on grant_cnt, slice i at [i*CNT_WIDTH +: CNT_WIDTH].
- Undefined: counters and the grant_cnt port are absent. Arbitration behaviour is identical.

Test Plan:
- Reset, then no stimulus: after rst_n=0 for 2 cycles, tag_req_vld=0, tag_req_src=0, src_rdy=000, alloc_rdy=0.
- NUM_SRC=3, src_vld=111 held, alloc_vld=1, tag_req_rdy=1, alloc_index increments 0,1,2,3: grants go to sources 0,1,2,0. tag_req_src sequence 0,1,2,0 appears one cycle later, with tag_req_index 0,1,2,3, one request per cycle.
- Backpressure with src_vld=010, pld=0xABCD, alloc_index=5, tag_req_rdy=0 for 4 cycles after the first load:
  - tag_req_vld=1, pld=0xABCD, index=5, src=1, all held stable.
  - No further src_rdy/alloc_rdy during the stall.
  - On tag_req_rdy=1, the next request loads in the same cycle.
- alloc_vld=0 with src_vld=101: src_rdy=000, alloc_rdy=0, tag_req_vld stays 0, ptr unchanged. alloc_vld=1 next cycle grants source 0.
- ptr=2, src_vld=011: winner is source 0 (wrap), ptr becomes 1. The next grant goes to source 1.
- With ARB_GRANT_CNT_EN, CNT_WIDTH=2, src_vld=001 for 6 grants: grant_cnt slice 0 = 3 (saturated), slices 1 and 2 = 0.

Source files
------------

// File: rtl/icache_req_rr_arb.sv
// Round-robin merge of NUM_SRC icache request channels into one registered tag-pipe request stream.
// Each grant also consumes one MSHR index. Optional per-source grant counters: ARB_GRANT_CNT_EN.
module icache_req_rr_arb #(
  parameter int unsigned NUM_SRC   = 3,
  parameter int unsigned PLD_WIDTH = 64,
  parameter int unsigned IDX_WIDTH = 3,
  parameter int unsigned CNT_WIDTH = 16,
  localparam int unsigned SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             src_vld,
  output logic [NUM_SRC-1:0]             src_rdy,
  input  logic [NUM_SRC*PLD_WIDTH-1:0]   src_pld,
  input  logic                           alloc_vld,
  input  logic [IDX_WIDTH-1:0]           alloc_index,
  output logic                           alloc_rdy,
  output logic                           tag_req_vld,
  input  logic                           tag_req_rdy,
  output logic [PLD_WIDTH-1:0]           tag_req_pld,
  output logic [IDX_WIDTH-1:0]           tag_req_index,
  output logic [SRC_W-1:0]               tag_req_src
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [NUM_SRC*CNT_WIDTH-1:0]   grant_cnt
`endif
);

  logic [SRC_W-1:0]     ptr;
  logic [SRC_W-1:0]     win;
  logic [PLD_WIDTH-1:0] win_pld;
  logic                 any_vld;
  logic                 slot_free;
  logic                 load;
  int unsigned          cand;
  logic                 found;

  // Rotating search: first requester at or after ptr, wrapping modulo NUM_SRC.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = (int'(ptr) + k) % NUM_SRC;
      if (!found && src_vld[cand]) begin
        win   = SRC_W'(cand);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_pld = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (SRC_W'(i) == win) win_pld = src_pld[i*PLD_WIDTH +: PLD_WIDTH];
    end
  end

  assign any_vld   = |src_vld;
  assign slot_free = !tag_req_vld || tag_req_rdy;
  assign load      = any_vld && alloc_vld && slot_free;
  assign alloc_rdy = load;

  always_comb begin
    src_rdy = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_rdy[i] = load && (SRC_W'(i) == win);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_req_vld   <= 1'b0;
      tag_req_pld   <= '0;
      tag_req_index <= '0;
      tag_req_src   <= '0;
      ptr           <= '0;
    end else if (load) begin
      tag_req_vld   <= 1'b1;
      tag_req_pld   <= win_pld;
      tag_req_index <= alloc_index;
      tag_req_src   <= win;
      ptr           <= (win == SRC_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
    end else if (tag_req_vld && tag_req_rdy) begin
      tag_req_vld   <= 1'b0;
    end
  end

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt [NUM_SRC];

  // Saturating: a counter parked at all-ones stays there until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (src_rdy[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_icache_req_rr_arb.sv
// Bench for icache_req_rr_arb: directed scenarios plus randomized traffic against a queue-free
// behavioural model (rotating priority by modulo search, registered output slot).
module tb_icache_req_rr_arb;
  localparam int unsigned N  = 3;
  localparam int unsigned PW = 16;
  localparam int unsigned IW = 3;
`ifdef ARB_GRANT_CNT_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 16;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    src_vld = '0;
  logic [N-1:0]    src_rdy;
  logic [N*PW-1:0] src_pld = '0;
  logic            alloc_vld = 1'b0;
  logic [IW-1:0]   alloc_index = '0;
  logic            alloc_rdy;
  logic            tag_req_vld;
  logic            tag_req_rdy = 1'b0;
  logic [PW-1:0]   tag_req_pld;
  logic [IW-1:0]   tag_req_index;
  logic [1:0]      tag_req_src;
`ifdef ARB_GRANT_CNT_EN
  logic [N*CW-1:0] grant_cnt;
`endif

  icache_req_rr_arb #(
    .NUM_SRC   (N),
    .PLD_WIDTH (PW),
    .IDX_WIDTH (IW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_vld       (src_vld),
    .src_rdy       (src_rdy),
    .src_pld       (src_pld),
    .alloc_vld     (alloc_vld),
    .alloc_index   (alloc_index),
    .alloc_rdy     (alloc_rdy),
    .tag_req_vld   (tag_req_vld),
    .tag_req_rdy   (tag_req_rdy),
    .tag_req_pld   (tag_req_pld),
    .tag_req_index (tag_req_index),
    .tag_req_src   (tag_req_src)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt     (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_ptr;
  bit          m_vld;
  logic [PW-1:0] m_pld;
  int          m_idx, m_src;
  int          m_cnt [N];
  logic [PW-1:0] pl [N];
  bit          rst_req;
  int          cur_ai;
  bit          cur_tr;
  int          e_win;
  bit          e_load;
  logic [N-1:0] e_rdy;

  task automatic apply(input logic [N-1:0] v, input bit av, input int ai, input bit tr);
    @(negedge clk);
    rst_n = !rst_req;
    src_vld = v;
    alloc_vld = av;
    alloc_index = IW'(ai);
    tag_req_rdy = tr;
    for (int i = 0; i < N; i++) src_pld[i*PW +: PW] = pl[i];
    cur_ai = ai;
    cur_tr = tr;
    e_win = -1;
    for (int k = 0; k < N; k++) if (e_win < 0 && v[(m_ptr + k) % N]) e_win = (m_ptr + k) % N;
    e_load = (e_win >= 0) && av && (!m_vld || tr);
    e_rdy = e_load ? (N'(1) << e_win) : '0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_req) begin
      m_vld = 0; m_pld = '0; m_idx = 0; m_src = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (e_load) begin
      m_vld = 1; m_pld = pl[e_win]; m_idx = cur_ai % (1 << IW); m_src = e_win;
      m_ptr = (e_win + 1) % N;
      if (m_cnt[e_win] < (1 << CW) - 1) m_cnt[e_win]++;
    end else if (m_vld && cur_tr) begin
      m_vld = 0;
    end
  endtask

  task automatic do_reset();
    rst_req = 1;
    repeat (2) begin apply('0, 0, 0, 0); tick(); end
    rst_req = 0;
  endtask

  task automatic test_reset();
    do_reset();
    apply('0, 0, 0, 0);
    checks++; if (tag_req_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", tag_req_vld); end
    checks++; if (tag_req_src !== 2'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", tag_req_src); end
    checks++; if (src_rdy !== 3'b000) begin errors++; $display("FAIL reset_src_rdy got=%b exp=000", src_rdy); end
    checks++; if (alloc_rdy !== 1'b0) begin errors++; $display("FAIL reset_alloc_rdy got=%b exp=0", alloc_rdy); end
    tick();
  endtask

  task automatic test_round_robin();
    int seq [4] = '{0, 1, 2, 0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) pl[i] = PW'($urandom);
      apply((c < 4) ? 3'b111 : 3'b000, c < 4, c, 1);
      if (c < 4) begin
        checks++; if (src_rdy !== (N'(1) << seq[c])) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp_src=%0d", c, src_rdy, seq[c]); end
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL rr_alloc c=%0d got=%b exp=1", c, alloc_rdy); end
      end
      if (c > 0) begin
        checks++; if (tag_req_vld !== 1'b1 || tag_req_src !== 2'(seq[c-1]) || tag_req_index !== IW'(c-1))
          begin errors++; $display("FAIL rr_out c=%0d got vld=%b src=%0d idx=%0d exp 1/%0d/%0d", c, tag_req_vld, tag_req_src, tag_req_index, seq[c-1], c-1); end
        checks++; if (tag_req_pld !== m_pld) begin errors++; $display("FAIL rr_pld c=%0d got=%h exp=%h", c, tag_req_pld, m_pld); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    pl[0] = 16'h1111; pl[1] = 16'hABCD; pl[2] = 16'h2222;
    apply(3'b010, 1, 5, 0);
    checks++; if (src_rdy !== 3'b010 || alloc_rdy !== 1'b1) begin errors++; $display("FAIL bp_first got rdy=%b alloc=%b exp 010/1", src_rdy, alloc_rdy); end
    tick();
    pl[1] = 16'h5A5A;
    for (int c = 0; c < 4; c++) begin
      apply(3'b010, 1, 6, 0);
      checks++; if (src_rdy !== 3'b000 || alloc_rdy !== 1'b0) begin errors++; $display("FAIL bp_stall_rdy c=%0d got rdy=%b alloc=%b exp 000/0", c, src_rdy, alloc_rdy); end
      checks++; if (tag_req_vld !== 1'b1 || tag_req_pld !== 16'hABCD || tag_req_index !== 3'd5 || tag_req_src !== 2'd1)
        begin errors++; $display("FAIL bp_hold c=%0d got vld=%b pld=%h idx=%0d src=%0d exp 1/abcd/5/1", c, tag_req_vld, tag_req_pld, tag_req_index, tag_req_src); end
      tick();
    end
    apply(3'b010, 1, 6, 1);
    checks++; if (src_rdy !== 3'b010 || alloc_rdy !== 1'b1) begin errors++; $display("FAIL bp_reload got rdy=%b alloc=%b exp 010/1", src_rdy, alloc_rdy); end
    tick();
    apply(3'b000, 0, 0, 1);
    checks++; if (tag_req_vld !== 1'b1 || tag_req_pld !== 16'h5A5A || tag_req_index !== 3'd6)
      begin errors++; $display("FAIL bp_next got vld=%b pld=%h idx=%0d exp 1/5a5a/6", tag_req_vld, tag_req_pld, tag_req_index); end
    tick();
    apply(3'b000, 0, 0, 1);
    checks++; if (tag_req_vld !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", tag_req_vld); end
    tick();
  endtask

  task automatic test_no_alloc();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      apply(3'b101, 0, 4, 1);
      checks++; if (src_rdy !== 3'b000 || alloc_rdy !== 1'b0 || tag_req_vld !== 1'b0)
        begin errors++; $display("FAIL noalloc c=%0d got rdy=%b alloc=%b vld=%b exp 000/0/0", c, src_rdy, alloc_rdy, tag_req_vld); end
      tick();
    end
    apply(3'b101, 1, 4, 1);
    checks++; if (src_rdy !== 3'b001) begin errors++; $display("FAIL noalloc_then_grant got=%b exp=001", src_rdy); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    apply(3'b010, 1, 1, 1); tick();
    apply(3'b011, 1, 2, 1);
    checks++; if (src_rdy !== 3'b001) begin errors++; $display("FAIL wrap_grant got=%b exp=001", src_rdy); end
    tick();
    apply(3'b011, 1, 3, 1);
    checks++; if (src_rdy !== 3'b010) begin errors++; $display("FAIL wrap_next got=%b exp=010", src_rdy); end
    checks++; if (tag_req_src !== 2'd0) begin errors++; $display("FAIL wrap_src got=%0d exp=0", tag_req_src); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) pl[i] = PW'($urandom);
      rst_req = ($urandom_range(0, 49) == 0);
      apply(N'($urandom), $urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 9) < 6);
      checks++; if (src_rdy !== e_rdy || alloc_rdy !== e_load)
        begin errors++; $display("FAIL rand_comb c=%0d got rdy=%b alloc=%b exp %b/%b", c, src_rdy, alloc_rdy, e_rdy, e_load); end
      checks++; if (tag_req_vld !== m_vld || tag_req_pld !== m_pld || tag_req_index !== IW'(m_idx) || tag_req_src !== 2'(m_src))
        begin errors++; $display("FAIL rand_out c=%0d got %b/%h/%0d/%0d exp %b/%h/%0d/%0d", c, tag_req_vld, tag_req_pld, tag_req_index, tag_req_src, m_vld, m_pld, m_idx, m_src); end
`ifdef ARB_GRANT_CNT_EN
      for (int i = 0; i < N; i++) begin
        checks++; if (grant_cnt[i*CW +: CW] !== CW'(m_cnt[i])) begin errors++; $display("FAIL rand_cnt c=%0d src=%0d got=%0d exp=%0d", c, i, grant_cnt[i*CW +: CW], m_cnt[i]); end
      end
`endif
      tick();
    end
    rst_req = 0;
  endtask

`ifdef ARB_GRANT_CNT_EN
  task automatic test_grant_cnt();
    do_reset();
    for (int c = 0; c < 6; c++) begin apply(3'b001, 1, c, 1); tick(); end
    apply('0, 0, 0, 1);
    checks++; if (grant_cnt[0 +: CW] !== 2'd3) begin errors++; $display("FAIL cnt_sat got=%0d exp=3", grant_cnt[0 +: CW]); end
    checks++; if (grant_cnt[CW +: 2*CW] !== '0) begin errors++; $display("FAIL cnt_other got=%b exp=0", grant_cnt[CW +: 2*CW]); end
    tick();
  endtask
`endif

  initial begin
    rst_req = 1;
    for (int i = 0; i < N; i++) pl[i] = '0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_no_alloc();
    test_wrap();
`ifdef ARB_GRANT_CNT_EN
    test_grant_cnt();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
